// File: rtl/shift_add_mult4b_if.sv
// Handshake and operand/result bundle for the 4x4 shift-add multiplier.
interface shift_add_mult4b_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input product);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output product);
endinterface

// File: rtl/shift_add_mult4b.sv
// Sequential 4x4 unsigned multiplier: one shift-add step per CALC cycle,
// four steps per product, single-cycle done pulse with registered result.
module shift_add_mult4b (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_mult4b_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t     r_state;
  logic [8:0] r_acc;
  logic [3:0] r_mcand;
  logic [1:0] r_count;
  logic [7:0] r_product;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_addend;
  logic [3:0] w_sum;
  logic       w_carry;
  logic       w_unused_acc_msb;

  assign w_addend         = r_acc[0] ? r_mcand : '0;
  assign w_unused_acc_msb = r_acc[8];

  // Explicit ripple chain so the partial-product add stays 4 bits wide.
  always_comb begin
    logic c;
    c     = 1'b0;
    w_sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_sum[i] = r_acc[4+i] ^ w_addend[i] ^ c;
      c        = (r_acc[4+i] & w_addend[i]) | (c & (r_acc[4+i] ^ w_addend[i]));
    end
    w_carry = c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= bus.a;
            r_acc   <= {5'b0, bus.b};
            r_count <= '0;
            r_state <= S_CALC;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc   <= {1'b0, w_carry, w_sum, r_acc[3:1]};
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_state   <= S_DONE;
            r_product <= {w_carry, w_sum, r_acc[3:1]};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_shift_add_mult4b.sv
// Scoreboard bench for shift_add_mult4b: expected product and done cycle
// are queued at start and matched when done is observed.
module tb_shift_add_mult4b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] prod;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  shift_add_mult4b_if bus ();

  shift_add_mult4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit expect_done);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    if (expect_done) begin
      e.prod     = {4'b0, a} * {4'b0, b};
      e.done_cyc = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_excl", {31'b0, bus.busy & bus.done}, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", {24'b0, bus.product}, {24'b0, e.prod});
          check("latency", cyc, e.done_cyc);
        end
      end
    end
  end

  int unsigned perm [256];

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_product", {24'b0, bus.product}, 0);

    // First edge with reset released also accepts start.
    rst_n = 1'b1;
    start_op(4'b1011, 4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("busy_calc", {31'b0, bus.busy}, 1);
      @(negedge clk);
    end
    check("busy_after", {31'b0, bus.busy}, 0);
    wait_drain();

    @(negedge clk);
    start_op(4'hF, 4'hF, 1'b1);
    wait_drain();
    @(negedge clk);
    start_op(4'h0, 4'h9, 1'b1);
    wait_drain();
    @(negedge clk);
    start_op(4'h9, 4'h0, 1'b1);
    wait_drain();

    // Second start during CALC must be ignored.
    @(negedge clk);
    start_op(4'd3, 4'd5, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd7;
    bus.b     = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // Reset in the second CALC cycle aborts without a done pulse.
    @(negedge clk);
    start_op(4'd6, 4'd7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, bus.busy}, 0);
    check("abort_done", {31'b0, bus.done}, 0);
    check("abort_product", {24'b0, bus.product}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_product_hold", {24'b0, bus.product}, 0);

    // Back-to-back: start during DONE.
    @(negedge clk);
    start_op(4'd2, 4'd3, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("b2b_done_seen", {31'b0, bus.done}, 1);
    start_op(4'd4, 4'd4, 1'b1);
    wait_drain();

    for (int unsigned i = 0; i < 256; i++) perm[i] = i;
    for (int unsigned i = 255; i > 0; i--) begin
      int unsigned j;
      int unsigned t;
      j       = $urandom_range(i, 0);
      t       = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int unsigned i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(perm[i]);
      @(negedge clk);
      start_op(ab[7:4], ab[3:0], 1'b1);
      repeat (3) @(negedge clk);
    end
    wait_drain();
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
